// File: rtl/umultadd_tree.sv
// Pipelined N-term sum-of-products with optional running accumulation.
// Stages: S0 capture, S1 products, T1..TK adder tree, X extend, R accumulate.
module umultadd_tree #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned NTERMS = 4,
  parameter int unsigned SIGNED = 0,
  parameter int unsigned ACCW   = 2*DWIDTH + $clog2(NTERMS) + 8
) (
  input  logic                     clk,
  input  logic                     aclr,
  input  logic                     in_valid,
  input  logic [NTERMS*DWIDTH-1:0] a,
  input  logic [NTERMS*DWIDTH-1:0] b,
  input  logic                     acc_en,
  input  logic                     acc_clr,
  output logic                     out_valid,
  output logic [ACCW-1:0]          out,
  output logic                     ovf
);

  localparam int unsigned K  = $clog2(NTERMS);
  localparam int unsigned PW = 2*DWIDTH;
  localparam int unsigned SW = PW + K;
  // Sideband stages: S0, S1, T1..TK, X
  localparam int unsigned NV = K + 3;

  if (ACCW < SW) begin : g_bad_accw
    $error("umultadd_tree: ACCW narrower than the tree sum");
  end
  if (NTERMS < 2 || (NTERMS & (NTERMS - 1)) != 0) begin : g_bad_nterms
    $error("umultadd_tree: NTERMS must be a power of 2, >= 2");
  end

  logic [NTERMS*DWIDTH-1:0] a_d, a_q, b_d, b_q;
  logic [NV-1:0]            vld_d, vld_q, en_d, en_q, clr_d, clr_q;

  always_comb begin
    a_d   = in_valid ? a : a_q;
    b_d   = in_valid ? b : b_q;
    vld_d = {vld_q[NV-2:0], in_valid};
    en_d  = {en_q[NV-2:0], acc_en};
    clr_d = {clr_q[NV-2:0], acc_clr};
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      a_q   <= '0;
      b_q   <= '0;
      vld_q <= '0;
      en_q  <= '0;
      clr_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      vld_q <= vld_d;
      en_q  <= en_d;
      clr_q <= clr_d;
    end
  end

  // Level 0 holds the products; level l holds NTERMS>>l partial sums, PW+l bits wide
  for (genvar l = 0; l <= K; l++) begin : g_lvl
    localparam int unsigned W   = PW + l;
    localparam int unsigned CNT = NTERMS >> l;
    logic [W-1:0] s_d [CNT];
    logic [W-1:0] s_q [CNT];

    if (l == 0) begin : g_mul
      always_comb begin
        logic [PW-1:0] xa, xb;
        xa = '0;
        xb = '0;
        for (int i = 0; i < CNT; i++) begin
          if (SIGNED != 0) begin
            xa = PW'($signed(a_q[i*DWIDTH +: DWIDTH]));
            xb = PW'($signed(b_q[i*DWIDTH +: DWIDTH]));
          end else begin
            xa = PW'(a_q[i*DWIDTH +: DWIDTH]);
            xb = PW'(b_q[i*DWIDTH +: DWIDTH]);
          end
          s_d[i] = xa * xb;
        end
      end
    end else begin : g_add
      always_comb begin
        for (int i = 0; i < CNT; i++) begin
          if (SIGNED != 0)
            s_d[i] = W'($signed(g_lvl[l-1].s_q[2*i])) + W'($signed(g_lvl[l-1].s_q[2*i+1]));
          else
            s_d[i] = W'(g_lvl[l-1].s_q[2*i]) + W'(g_lvl[l-1].s_q[2*i+1]);
        end
      end
    end

    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        for (int i = 0; i < CNT; i++) s_q[i] <= '0;
      end else begin
        for (int i = 0; i < CNT; i++) s_q[i] <= s_d[i];
      end
    end
  end

  // Extension register keeps the accumulator adder off the tree's critical path
  logic [ACCW-1:0] ext_d, ext_q;

  always_comb begin
    if (SIGNED != 0) ext_d = ACCW'($signed(g_lvl[K].s_q[0]));
    else             ext_d = ACCW'(g_lvl[K].s_q[0]);
  end

  logic [ACCW-1:0] out_d, out_q;
  logic            out_valid_d, out_valid_q, ovf_d, ovf_q;
  logic [ACCW:0]   acc_wide;
  logic            acc_ovf;

  always_comb begin
    out_d       = out_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    acc_wide    = (ACCW+1)'(out_q) + (ACCW+1)'(ext_q);
    if (SIGNED != 0)
      acc_ovf = (out_q[ACCW-1] == ext_q[ACCW-1]) && (acc_wide[ACCW-1] != out_q[ACCW-1]);
    else
      acc_ovf = acc_wide[ACCW];
    if (vld_q[NV-1]) begin
      out_valid_d = 1'b1;
      if (en_q[NV-1] && !clr_q[NV-1]) begin
        out_d = acc_wide[ACCW-1:0];
        ovf_d = ovf_q | acc_ovf;
      end else begin
        out_d = ext_q;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ext_q       <= '0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      ext_q       <= ext_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_umultadd_tree.sv
// Bench for umultadd_tree: unsigned, signed and narrow-ACCW instances share one stimulus stream.
module tb_umultadd_tree;

  logic        clk;
  logic        aclr;
  logic        in_valid;
  logic [63:0] a, b;
  logic        acc_en, acc_clr;

  logic        ov_u, ov_s, ov_n;
  logic [41:0] out_u, out_s;
  logic [33:0] out_n;
  logic        ovf_u, ovf_s, ovf_n;

  umultadd_tree #(.DWIDTH(16), .NTERMS(4), .SIGNED(0)) dut_u (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .a(a), .b(b), .acc_en(acc_en),
    .acc_clr(acc_clr), .out_valid(ov_u), .out(out_u), .ovf(ovf_u));
  umultadd_tree #(.DWIDTH(16), .NTERMS(4), .SIGNED(1)) dut_s (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .a(a), .b(b), .acc_en(acc_en),
    .acc_clr(acc_clr), .out_valid(ov_s), .out(out_s), .ovf(ovf_s));
  umultadd_tree #(.DWIDTH(16), .NTERMS(4), .SIGNED(0), .ACCW(34)) dut_n (
    .clk(clk), .aclr(aclr), .in_valid(in_valid), .a(a), .b(b), .acc_en(acc_en),
    .acc_clr(acc_clr), .out_valid(ov_n), .out(out_n), .ovf(ovf_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [41:0] u;
    logic [41:0] s;
    logic [33:0] n;
    logic        fu, fs, fn;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [41:0] m_u, m_s;
  logic [33:0] m_n;
  logic        m_fu, m_fs, m_fn;

  localparam longint SMAX = 64'sh1FF_FFFF_FFFF;
  localparam longint SMIN = -64'sh200_0000_0000;

  // Scoreboard: each cycle either the oldest expected result is due, or no out_valid may appear
  always @(negedge clk) begin
    if (!aclr) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        mon_e = sbq.pop_front();
        n_chk++;
        if ({ov_u, ov_s, ov_n} !== 3'b111 || out_u !== mon_e.u || out_s !== mon_e.s ||
            out_n !== mon_e.n || {ovf_u, ovf_s, ovf_n} !== {mon_e.fu, mon_e.fs, mon_e.fn}) begin
          n_fail++;
          $display("FAIL result cyc=%0d: valid=%b out u/s/n=%h/%h/%h ovf=%b%b%b, want valid=111 out=%h/%h/%h ovf=%b%b%b",
                   cyc, {ov_u, ov_s, ov_n}, out_u, out_s, out_n, ovf_u, ovf_s, ovf_n,
                   mon_e.u, mon_e.s, mon_e.n, mon_e.fu, mon_e.fs, mon_e.fn);
        end
      end else begin
        n_chk++;
        if ({ov_u, ov_s, ov_n} !== 3'b000) begin
          n_fail++;
          $display("FAIL spurious_valid cyc=%0d: valid=%b, want 000", cyc, {ov_u, ov_s, ov_n});
        end
      end
    end
  end

  task automatic model_clear();
    sbq.delete();
    m_u = '0; m_s = '0; m_n = '0;
    m_fu = 1'b0; m_fs = 1'b0; m_fn = 1'b0;
  endtask

  task automatic drive_beat(input logic [63:0] ap, input logic [63:0] bp,
                            input logic en, input logic clr);
    longint su, ss, r;
    logic [63:0] t;
    logic [15:0] x, y;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ap; b = bp; acc_en = en; acc_clr = clr;
    su = 0; ss = 0;
    for (int i = 0; i < 4; i++) begin
      x = ap[i*16 +: 16];
      y = bp[i*16 +: 16];
      su += longint'(x) * longint'(y);
      ss += longint'($signed(x)) * longint'($signed(y));
    end
    if (en && !clr) begin
      t = {22'b0, m_u} + su;  m_fu = m_fu | t[42];  m_u = t[41:0];
      t = {30'b0, m_n} + su;  m_fn = m_fn | t[34];  m_n = t[33:0];
      r = longint'($signed(m_s)) + ss;
      m_fs = m_fs | (r > SMAX) | (r < SMIN);
      m_s = r[41:0];
    end else begin
      m_u = su[41:0]; m_n = su[33:0]; m_s = ss[41:0];
      m_fu = 1'b0; m_fs = 1'b0; m_fn = 1'b0;
    end
    e.due = cyc + 6;
    e.u = m_u; e.s = m_s; e.n = m_n;
    e.fu = m_fu; e.fs = m_fs; e.fn = m_fn;
    sbq.push_back(e);
  endtask

  // Bubbles carry junk operands and sidebands, which must not leak into out
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      acc_en = 1'($urandom);
      acc_clr = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    idle(1);
    while (sbq.size() > 0 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    if (sbq.size() > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    aclr = 1'b1; in_valid = 1'b0; a = '1; b = '1; acc_en = 1'b1; acc_clr = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({ov_u, ov_s, ov_n, ovf_u, ovf_s, ovf_n} !== 6'b0 || out_u !== 42'd0 ||
        out_s !== 42'd0 || out_n !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ovf=%b out=%h/%h/%h, want all zero",
               {ov_u, ov_s, ov_n}, {ovf_u, ovf_s, ovf_n}, out_u, out_s, out_n);
    end
    aclr = 1'b0;
  endtask

  task automatic test_single();
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 1'b0);
    drain();
    n_chk++;
    if (out_u !== 42'd70 || out_s !== 42'd70) begin
      n_fail++;
      $display("FAIL single_sum: out u/s=%0d/%0d, want 70", out_u, out_s);
    end
  endtask

  task automatic test_max();
    drive_beat('1, '1, 1'b0, 1'b0);
    drain();
    n_chk++;
    if (out_u !== 42'h3_FFF8_0004 || out_n !== 34'h3_FFF8_0004 || ovf_u !== 1'b0) begin
      n_fail++;
      $display("FAIL max_operands: out u/n=%h/%h ovf=%b, want 3fff80004 ovf=0", out_u, out_n, ovf_u);
    end
  endtask

  task automatic test_accum();
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b1);
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0);
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0);
    drain();
    n_chk++;
    if (out_u !== 42'd210) begin
      n_fail++;
      $display("FAIL accum_chain: out=%0d, want 210", out_u);
    end
  endtask

  task automatic test_hold();
    int d0;
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 1'b0);
    d0 = sbq[sbq.size()-1].due;
    idle(2);
    drive_beat(64'h0001_0001_0001_0001, 64'h0001_0001_0001_0001, 1'b0, 1'b0);
    idle(1);
    do begin @(negedge clk); #1; end while (cyc < d0 + 1);
    for (int k = 0; k < 2; k++) begin
      n_chk++;
      if (out_u !== 42'd70 || ov_u !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_gap%0d: out=%0d valid=%b, want 70 valid=0", k, out_u, ov_u);
      end
      @(negedge clk); #1;
    end
    drain();
  endtask

  task automatic test_signed();
    drive_beat({16'd4, 16'hFFFD, 16'd2, 16'hFFFF}, {16'd8, 16'd7, 16'hFFFA, 16'd5}, 1'b0, 1'b0);
    drain();
    n_chk++;
    if (out_s !== 42'h3FF_FFFF_FFFA || ovf_s !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_sum: out=%h ovf=%b, want 3fffffffffa ovf=0", out_s, ovf_s);
    end
  endtask

  task automatic test_ovf();
    drive_beat('1, '1, 1'b1, 1'b1);
    drive_beat('1, '1, 1'b1, 1'b0);
    drain();
    n_chk++;
    if (out_n !== 34'h3_FFF0_0008 || ovf_n !== 1'b1 || ovf_u !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_set: out_n=%h ovf n/u=%b%b, want 3fff00008 ovf=10", out_n, ovf_n, ovf_u);
    end
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b1);
    drain();
    n_chk++;
    if (ovf_n !== 1'b0 || out_n !== 34'd70) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b out=%0d, want ovf=0 out=70", ovf_n, out_n);
    end
  endtask

  task automatic test_aclr_mid();
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b0, 1'b0);
    idle(1);
    @(posedge clk); #1;
    aclr = 1'b1;
    model_clear();
    @(posedge clk); #1;
    aclr = 1'b0;
    idle(8);
    n_chk++;
    if (out_u !== 42'd0 || out_n !== 34'd0 || {ovf_u, ovf_s, ovf_n} !== 3'b000) begin
      n_fail++;
      $display("FAIL aclr_flush: out u/n=%h/%h ovf=%b, want 0", out_u, out_n, {ovf_u, ovf_s, ovf_n});
    end
    drive_beat({16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 1'b1, 1'b0);
    drain();
    n_chk++;
    if (out_u !== 42'd70) begin
      n_fail++;
      $display("FAIL aclr_recover: out=%0d, want 70", out_u);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 5) == 0) idle(1);
      drive_beat({$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_accum();
    test_hold();
    test_signed();
    test_ovf();
    test_aclr_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
